sprite_blitter: RTL

- Reader-side engine for the 3-bit palette-index sprite ROMs: walks one sprite pixel by pixel and drives the ROM read address.
- Consumes the ROM's combinational 3-bit index output.
- Writes opaque, on-screen pixels into the framebuffer write port with a ready/stall handshake.
- Sits between game logic (which issues draw requests) and the shared framebuffer.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_addr_gen.sv | 93 +++++++++
 rtl/sprite_blitter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite blitter.
package sprite_pkg;

    // One sprite ROM / framebuffer pixel: a 3-bit palette index.
    typedef logic [2:0] pix_idx_t;

    // Palette index that marks a see-through pixel; it is never written.
    localparam pix_idx_t TRANSPARENT_IDX = 3'd0;

    // Default sprite and screen geometry.
    localparam int SPR_W_DEF = 48;
    localparam int SPR_H_DEF = 52;
    localparam int SCR_W_DEF = 320;
    localparam int SCR_H_DEF = 240;

    // Blitter control states; also exported on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Column/row walker for one sprite. Each advance loads the current pixel's
// ROM address and screen destination into output registers and steps the
// counters. o_pix_valid marks that those registers hold a real pixel, and
// o_pix_last marks the final pixel of the sprite.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_advance,
    input  logic        i_flip_h,
    input  logic [9:0]  i_x0,
    input  logic [9:0]  i_y0,
    output logic [18:0] o_rom_addr,
    output logic [10:0] o_dest_x,
    output logic [10:0] o_dest_y,
    output logic        o_pix_valid,
    output logic        o_pix_last
);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(SPR_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_cnt_done;
    logic [18:0]   r_rom_addr;
    logic [10:0]   r_dest_x;
    logic [10:0]   r_dest_y;
    logic          r_pix_valid;
    logic          r_pix_last;

    logic          w_cnt_last;
    logic [CW-1:0] w_col_eff;
    logic [18:0]   w_addr_next;

    // Mirroring only changes which ROM column is read; the screen column
    // still follows the counter.
    assign w_cnt_last  = (r_col == COL_MAX) && (r_row == ROW_MAX);
    assign w_col_eff   = i_flip_h ? (COL_MAX - r_col) : r_col;
    assign w_addr_next = 19'(r_row) * 19'(SPR_W) + 19'(w_col_eff);

    // Counter walk plus registered address/destination of the current pixel.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_cnt_done  <= 1'b0;
            r_rom_addr  <= '0;
            r_dest_x    <= '0;
            r_dest_y    <= '0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
        end else if (i_clear) begin
            r_col       <= '0;
            r_row       <= '0;
            r_cnt_done  <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
        end else if (i_advance) begin
            if (!r_cnt_done) begin
                r_rom_addr  <= w_addr_next;
                r_dest_x    <= 11'(i_x0) + 11'(r_col);
                r_dest_y    <= 11'(i_y0) + 11'(r_row);
                r_pix_valid <= 1'b1;
                r_pix_last  <= w_cnt_last;
                if (w_cnt_last) begin
                    r_cnt_done <= 1'b1;
                end else if (r_col == COL_MAX) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                r_pix_valid <= 1'b0;
                r_pix_last  <= 1'b0;
            end
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_dest_x    = r_dest_x;
    assign o_dest_y    = r_dest_y;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_last  = r_pix_last;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite ROM and writes opaque, on-screen pixels to
// the framebuffer.
//
// Framebuffer handshake: fb_we is a valid flag and fb_ready its ready. A
// write retires at a clock edge where both are high. While fb_we is high and
// fb_ready is low, fb_we/fb_addr/fb_data hold and the whole walk freezes.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF,
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        flip_h,
    output logic        busy,
    output logic        done,
    output logic [18:0] rom_addr,
    input  logic [2:0]  rom_data,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [2:0]  fb_data,
    input  logic        fb_ready,
    output logic [1:0]  dbg_state
);
    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_x0;
    logic [9:0]  r_y0;
    logic        r_flip;
    logic        r_we;
    logic [16:0] r_fb_addr;
    pix_idx_t    r_fb_data;

    logic        w_clear;
    logic        w_advance;
    logic [10:0] w_dest_x;
    logic [10:0] w_dest_y;
    logic        w_pix_valid;
    logic        w_pix_last;
    logic        w_wr_valid;
    logic [16:0] w_fb_addr;

    // A pending write that the framebuffer refuses freezes the walk.
    assign w_clear   = (r_state == ST_IDLE) && start;
    assign w_advance = (r_state == ST_DRAW) && !(r_we && !fb_ready);

    sprite_addr_gen #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_addr_gen (
        .i_clk       (Clk),
        .i_reset     (Reset),
        .i_clear     (w_clear),
        .i_advance   (w_advance),
        .i_flip_h    (r_flip),
        .i_x0        (r_x0),
        .i_y0        (r_y0),
        .o_rom_addr  (rom_addr),
        .o_dest_x    (w_dest_x),
        .o_dest_y    (w_dest_y),
        .o_pix_valid (w_pix_valid),
        .o_pix_last  (w_pix_last)
    );

    // The clip test runs on the unwrapped 11-bit destination. The address
    // is only used for pixels that pass it, so the 17-bit result never wraps.
    assign w_wr_valid = w_pix_valid && (rom_data != TRANSPARENT_IDX) &&
                        (w_dest_x < 11'(SCR_W)) && (w_dest_y < 11'(SCR_H));
    assign w_fb_addr  = 17'(w_dest_y) * 17'(SCR_W) + 17'(w_dest_x);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. DRAW ends when the last pixel moves into the write
    // register. FLUSH ends once that register is empty or its write retires.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_DRAW;
            ST_DRAW:  if (w_advance && w_pix_valid && w_pix_last) w_state_next = ST_FLUSH;
            ST_FLUSH: if (!r_we || fb_ready) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Capture position and mirror flag when a draw request is accepted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x0   <= '0;
            r_y0   <= '0;
            r_flip <= 1'b0;
        end else if (w_clear) begin
            r_x0   <= x_pos;
            r_y0   <= y_pos;
            r_flip <= flip_h;
        end
    end

    // Write register: loads on every advance, holds while stalled, and
    // drains its final write during FLUSH.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_we      <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else if (w_advance) begin
            r_we <= w_wr_valid;
            if (w_wr_valid) begin
                r_fb_addr <= w_fb_addr;
                r_fb_data <= rom_data;
            end
        end else if ((r_state == ST_FLUSH) && fb_ready) begin
            r_we <= 1'b0;
        end
    end

    assign busy      = (r_state == ST_DRAW) || (r_state == ST_FLUSH);
    assign done      = (r_state == ST_DONE);
    assign fb_we     = r_we;
    assign fb_addr   = r_fb_addr;
    assign fb_data   = r_fb_data;
    assign dbg_state = r_state;

endmodule
